// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings and the alignment rule for the MEM-stage memory port.
package mem_access_pkg;
  localparam int LANE_W = 8;
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR} state_e;
  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    return size == SIZE_ILL || (size == SIZE_HALF && off[0]) || (size == SIZE_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [4:0]          sh;
  logic [LANE_W-1:0]   b;
  logic [2*LANE_W-1:0] h;
  logic [31:0]         mask;
  assign sh = {offset, 3'b000};
  assign b = 8'(rd_word >> sh);
  assign h = offset[1] ? rd_word[31:16] : rd_word[15:0];
  assign load_data = size == SIZE_BYTE ? {{24{b[7] & ~is_unsigned}}, b}
                   : size == SIZE_HALF ? {{16{h[15] & ~is_unsigned}}, h} : rd_word;
  // halfwords are aligned here, so the byte shift also places the half lane
  assign mask = size == SIZE_BYTE ? 32'h0000_00ff << sh
              : size == SIZE_HALF ? 32'h0000_ffff << sh : 32'hffff_ffff;
  assign merged = (old_word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a word-wide memory without byte enables (sub-word stores via RMW).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_req_valid,
  input  logic               i_req_write,
  input  logic [1:0]         i_req_size,
  input  logic               i_req_unsigned,
  input  logic [NB_ADDR+1:0] i_req_addr,
  input  logic [NB_DATA-1:0] i_req_wdata,
  output logic               o_ready,
  output logic               o_done,
  output logic               o_error,
  output logic [NB_DATA-1:0] o_rdata,
  output logic               o_mem_enable,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [NB_ADDR-1:0] o_mem_address,
  output logic [NB_DATA-1:0] o_mem_write_data,
  input  logic [NB_DATA-1:0] i_mem_read_data
);
  state_e             state, state_next;
  size_e              req_size, size_q;
  logic [NB_ADDR+1:0] addr_q;
  logic [NB_DATA-1:0] wdata_q, load_data, merged;
  logic               uns_q, accept;
  logic               done_d, error_d, en_d, rd_d, wr_d;
  logic [NB_DATA-1:0] rdata_d, mwdata_d;
  logic [NB_ADDR-1:0] maddr_d;
  assign req_size = size_e'(i_req_size);
  assign o_ready = state == IDLE;
  assign accept = o_ready && i_req_valid;
  mem_lane_align u_align (
    .rd_word    (i_mem_read_data),
    .old_word   (i_mem_read_data),
    .wdata      (wdata_q),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .load_data  (load_data),
    .merged     (merged)
  );
  always_comb begin
    state_next = state;
    done_d = 1'b0;
    error_d = 1'b0;
    rdata_d = o_rdata;
    en_d = 1'b0;
    rd_d = 1'b0;
    wr_d = 1'b0;
    maddr_d = '0;
    mwdata_d = '0;
    case (state)
      IDLE: if (accept) begin
        if (misaligned(req_size, i_req_addr[1:0])) error_d = 1'b1;
        else begin
          en_d = 1'b1;
          maddr_d = i_req_addr[NB_ADDR+1:2];
          rd_d = !(i_req_write && req_size == SIZE_WORD);
          wr_d = i_req_write && req_size == SIZE_WORD;
          mwdata_d = wr_d ? i_req_wdata : '0;
          state_next = !i_req_write ? RD : req_size == SIZE_WORD ? WR : RMW_RD;
        end
      end
      RD: state_next = RD_WAIT;
      RD_WAIT: begin
        rdata_d = load_data;
        done_d = 1'b1;
        state_next = IDLE;
      end
      RMW_RD: state_next = RMW_WAIT;
      RMW_WAIT: begin
        en_d = 1'b1;
        wr_d = 1'b1;
        maddr_d = addr_q[NB_ADDR+1:2];
        mwdata_d = merged;
        state_next = WR;
      end
      WR: begin
        done_d = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      size_q <= SIZE_BYTE;
      addr_q <= '0;
      wdata_q <= '0;
      uns_q <= 1'b0;
      o_done <= 1'b0;
      o_error <= 1'b0;
      o_rdata <= '0;
      o_mem_enable <= 1'b0;
      o_mem_read <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_address <= '0;
      o_mem_write_data <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        size_q <= req_size;
        addr_q <= i_req_addr;
        wdata_q <= i_req_wdata;
        uns_q <= i_req_unsigned;
      end
      o_done <= done_d;
      o_error <= error_d;
      o_rdata <= rdata_d;
      o_mem_enable <= en_d;
      o_mem_read <= rd_d;
      o_mem_write <= wr_d;
      o_mem_address <= maddr_d;
      o_mem_write_data <= mwdata_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus random requests against a byte-array reference memory.
module tb_mem_access_unit;
  localparam int NB_ADDR = 5;
  localparam int NB_DATA = 32;
  logic               i_clock = 1'b0;
  logic               i_reset_n = 1'b1;
  logic               i_req_valid = 1'b0;
  logic               i_req_write = 1'b0;
  logic [1:0]         i_req_size = 2'b00;
  logic               i_req_unsigned = 1'b0;
  logic [NB_ADDR+1:0] i_req_addr = '0;
  logic [NB_DATA-1:0] i_req_wdata = '0;
  logic               o_ready, o_done, o_error;
  logic [NB_DATA-1:0] o_rdata, o_mem_write_data;
  logic               o_mem_enable, o_mem_read, o_mem_write;
  logic [NB_ADDR-1:0] o_mem_address;
  logic [NB_DATA-1:0] mem_rdata = '0;
  logic [31:0]        mem [32] = '{default: '0};
  logic [7:0]         ref_b [128] = '{default: '0};
  logic [31:0]        last_load = '0;
  int n_rd = 0, n_wr = 0;
  int checks = 0, failures = 0;

  mem_access_unit #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_req_valid(i_req_valid),
    .i_req_write(i_req_write), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .o_ready(o_ready),
    .o_done(o_done), .o_error(o_error), .o_rdata(o_rdata),
    .o_mem_enable(o_mem_enable), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
    .i_mem_read_data(mem_rdata)
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) begin
    mem_rdata <= (o_mem_enable && o_mem_read) ? mem[o_mem_address] : '0;
    if (o_mem_enable && o_mem_write) mem[o_mem_address] <= o_mem_write_data;
    n_rd <= n_rd + ((o_mem_enable && o_mem_read) ? 1 : 0);
    n_wr <= n_wr + ((o_mem_enable && o_mem_write) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  task automatic access(input bit wr, input logic [1:0] sz, input bit uns, input int addr, input logic [31:0] wd);
    int r0, w0, cyc, nb, exp_lat;
    bit err, got_done, got_err;
    longint v;
    err = sz == 2'd3 || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    r0 = n_rd;
    w0 = n_wr;
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_size = sz;
    i_req_unsigned = uns;
    i_req_addr = 7'(addr);
    i_req_wdata = wd;
    @(posedge i_clock);
    @(negedge i_clock);
    i_req_valid = 1'b0;
    i_req_wdata = $urandom;
    cyc = 1;
    got_done = 1'b0;
    got_err = 1'b0;
    while (cyc < 10) begin
      if (o_done || o_error) begin
        got_done = o_done;
        got_err = o_error;
        break;
      end
      cyc++;
      @(negedge i_clock);
    end
    exp_lat = err ? 1 : !wr ? 3 : sz == 2'd2 ? 2 : 4;
    chk("error", 32'(got_err), 32'(err));
    chk("done", 32'(got_done), 32'(!err));
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("mem_reads", 32'(n_rd - r0), err ? 0 : (!wr || sz != 2'd2) ? 1 : 0);
    chk("mem_writes", 32'(n_wr - w0), (!err && wr) ? 1 : 0);
    if (err) chk("ready_on_error", 32'(o_ready), 1);
    if (!err && wr) begin
      for (int i = 0; i < nb; i++) ref_b[addr+i] = wd[8*i+:8];
      chk("mem_word", mem[addr/4], ref_word(addr/4));
    end
    if (!err && !wr) begin
      v = 0;
      for (int i = 0; i < nb; i++) v += longint'(ref_b[addr+i]) << (8*i);
      if (!uns && nb < 4 && v >= (longint'(1) << (8*nb-1))) v -= longint'(1) << (8*nb);
      last_load = v[31:0];
      chk("rdata", o_rdata, last_load);
    end else chk("rdata_hold", o_rdata, last_load);
  endtask

  initial begin
    #1 i_reset_n = 1'b0;
    #2;
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_error", 32'(o_error), 0);
    chk("rst_enable", 32'(o_mem_enable), 0);
    chk("rst_rdata", o_rdata, 0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    @(negedge i_clock);
    access(1, 2'd2, 0, 4, 32'h8FF0FF01);
    chk("sw_word1", mem[1], 32'h8FF0FF01);
    access(0, 2'd2, 0, 4, 0);
    chk("lw", o_rdata, 32'h8FF0FF01);
    access(0, 2'd0, 0, 5, 0);
    chk("lb5", o_rdata, 32'hFFFFFFFF);
    access(0, 2'd0, 1, 5, 0);
    chk("lbu5", o_rdata, 32'h000000FF);
    access(0, 2'd0, 0, 4, 0);
    chk("lb4", o_rdata, 32'h00000001);
    access(0, 2'd1, 0, 6, 0);
    chk("lh6", o_rdata, 32'hFFFF8FF0);
    access(0, 2'd1, 1, 6, 0);
    chk("lhu6", o_rdata, 32'h00008FF0);
    access(0, 2'd1, 0, 4, 0);
    chk("lh4", o_rdata, 32'hFFFFFF01);
    access(1, 2'd0, 0, 7, 32'h123456AA);
    chk("sb7", mem[1], 32'hAAF0FF01);
    access(1, 2'd1, 0, 4, 32'hABCD1234);
    chk("sh4", mem[1], 32'hAAF01234);
    access(0, 2'd2, 0, 2, 0);
    access(1, 2'd1, 0, 5, 32'h1111);
    access(0, 2'd3, 0, 0, 0);
    access(1, 2'd2, 0, 8, 32'hCAFEBABE);
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_size = 2'd0;
    i_req_addr = 7'd8;
    i_req_wdata = 32'h55;
    @(posedge i_clock);
    @(negedge i_clock);
    i_req_valid = 1'b0;
    @(negedge i_clock);
    chk("busy_rmw", 32'(o_ready), 0);
    i_reset_n = 1'b0;
    #1;
    chk("rst_mid_rdata", o_rdata, 0);
    chk("rst_mid_ready", 32'(o_ready), 1);
    chk("rst_mid_enable", 32'(o_mem_enable), 0);
    @(negedge i_clock);
    chk("rst_mid_write", 32'(o_mem_write), 0);
    i_reset_n = 1'b1;
    last_load = '0;
    @(negedge i_clock);
    chk("word2_kept", mem[2], ref_word(2));
    access(0, 2'd2, 0, 8, 0);
    chk("lw_after_rst", o_rdata, 32'hCAFEBABE);
    for (int n = 0; n < 80; n++)
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 127)), $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-wide data memory port, placed in the MEM stage of the MIPS pipeline.
- Takes byte-addressed load/store requests (byte, halfword, word; signed/unsigned loads) from the pipeline and drives the memory's enable/read/write/address/data port.
- Sign/zero-extends load data.
- The memory has no byte enables, so sub-word stores are done as read-modify-write. The pipeline is stalled through o_ready while an access is in progress.

Parameters:
- NB_ADDR, 5, word-address width of the memory (32 words).
- NB_DATA, 32, data width. Fixed at 32; the lane logic assumes 4 bytes per word.

Ports:
- i_clock  in  1  clock; all state changes on rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request present; accepted on an edge where o_ready=1.
- i_req_write  in  1  1 = store, 0 = load.
- i_req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- i_req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend. Ignored for stores.
- i_req_addr  in  NB_ADDR+2  byte address. Word index = [NB_ADDR+1:2]; byte offset = [1:0].
- i_req_wdata  in  NB_DATA  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_ready  out  1  combinational, 1 only in IDLE.
- o_done  out  1  registered one-cycle pulse when a load or store completes.
- o_error  out  1  registered one-cycle pulse when a request is rejected as misaligned or illegal.
- o_rdata  out  NB_DATA  registered, extended load result; holds until the next load completes.
- o_mem_enable  out  1  memory enable.
- o_mem_read  out  1  memory read enable.
- o_mem_write  out  1  memory write enable.
- o_mem_address  out  NB_ADDR  memory word address.
- o_mem_write_data  out  NB_DATA  memory write data.
- i_mem_read_data  in  NB_DATA  memory read data. Registered in the memory: valid the cycle after a read-enabled edge, 0 after an edge without read.

Behaviour:
- Reset (async, i_reset_n=0):
  - state goes to IDLE.
  - o_done, o_error, o_rdata, and all o_mem_* outputs go to 0 immediately.
  - An access in flight is abandoned; a pending RMW write is not performed. Memory contents are not touched.
- All o_mem_* outputs are registered. They are 0 in every state except RD, RMW_RD and WR.
- Lanes are little-endian:
  - byte offset k maps to bits [8k+7:8k].
  - halfword offset 0 maps to [15:0]; offset 2 maps to [31:16].
- Misalignment check on accept. A request is an error if any of these hold:
  - size=11
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
- On an error: pulse o_error, do not assert o_done, make no memory access, stay in IDLE.
- IDLE: on i_req_valid, latch the request and branch:
  - load: drive enable=1, read=1, address; go to RD.
  - word store: drive enable=1, write=1, address, wdata; go to WR.
  - sub-word store: drive enable=1, read=1; go to RMW_RD.
- RD: memory captures the word. Clear mem outputs; go to RD_WAIT.
- RD_WAIT:
  - Extract the lane from i_mem_read_data and extend it.
  - Register the result in o_rdata, set o_done; go to IDLE.
  - Load latency: accepted at edge T, o_done/o_rdata valid in the cycle after edge T+2.
- RMW_RD: clear mem outputs; go to RMW_WAIT.
- RMW_WAIT:
  - Merge the store lane from the latched wdata into i_mem_read_data; other bytes are unchanged.
  - Drive enable=1, write=1, address, merged data; go to WR.
- WR: memory writes. Clear mem outputs, set o_done; go to IDLE.
  - Word store: o_done in the cycle after edge T+1.
  - Sub-word store: o_done in the cycle after edge T+3.
- Timing between requests:
  - o_done is high in IDLE, so a new request may be accepted in the same cycle (back-to-back).
  - Requests arriving while o_ready=0 are ignored. The pipeline must hold them.
- Addressing: no address arithmetic; the word index is taken directly, with no wrap logic needed.

Decomposition:
- Shared package mem_access_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - FSM state encodings (IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR)
  - byte-lane width constant
- Sub-module mem_lane_align (combinational):
  - load path: word, offset, size, unsigned → extended result
  - store path: old word, wdata, offset, size → merged word
- The FSM and registers stay in the top module.

Test Plan:
- Word store then load: SW 0x8FF0FF01 at 0x04, then LW 0x04 → mem word1=0x8FF0FF01; o_rdata=0x8FF0FF01; o_done 3 cycles after load accept.
- Byte load extension: LB 0x05 → 0xFFFFFFFF; LBU 0x05 → 0x000000FF; LB 0x04 → 0x00000001.
- Halfword load extension: LH 0x06 → 0xFFFF8FF0; LHU 0x06 → 0x00008FF0; LH 0x04 → 0xFFFFFF01.
- Sub-word stores:
  - SB 0xAA at 0x07 → one read then one write; word1=0xAAF0FF01; o_done at T+3.
  - SH 0x1234 at 0x04 → word1=0xAAF01234.
- Misaligned/illegal: LW 0x02, SH 0x05, size=11 → each gives an o_error pulse, o_mem_enable stays 0, o_ready stays 1, no o_done.
- Reset mid-RMW: assert i_reset_n=0 in RMW_WAIT during SB 0x55 at 0x08 → outputs 0 immediately, word2 unchanged, IDLE after release; a following LW 0x08 returns the old value.
